elevator_button_panel: RTL and testbench

- Input-conditioning front end for the two-car, 7-floor elevator controller.
- Takes the raw, asynchronous, bouncing push-button lines (12 hall call buttons, 9 buttons in each car) and synchronises and debounces each one.
- Turns each debounced press into a held request on the controller's `newRealFloorButton` / `newInternalButton1` / `newInternalButton2` inputs.
- Holds each request until the controller acknowledges it by lighting the matching lamp bit on its `current*` outputs, or until a timeout drops it.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/button_channel.sv | 102 ++++++++++
 rtl/elevator_button_panel.sv | 57 +++++
 tb/tb_elevator_button_panel.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator button-panel front end.
package elevator_pkg;

  localparam int unsigned NUM_HALL_BUTTONS   = 12;
  localparam int unsigned NUM_CAR_BUTTONS    = 9;
  localparam int unsigned NUM_PANEL_CHANNELS = 30;

  // Channel index map: hall [11:0] -> 0..11, car-1 [9:1] -> 12..20, car-2 [9:1] -> 21..29
  localparam int unsigned HALL_BASE = 0;
  localparam int unsigned CAR1_BASE = HALL_BASE + NUM_HALL_BUTTONS;
  localparam int unsigned CAR2_BASE = CAR1_BASE + NUM_CAR_BUTTONS;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    REQ_IDLE    = 1'b0,
    REQ_PENDING = 1'b1
  } req_state_e;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce, and request/timeout FSM.
module button_channel
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLKS = 4,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_lamp,
  output logic o_pending,
  output logic o_drop_c
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CLKS - 1);
  localparam logic [CNT_W-1:0] AGE_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_age;
  req_state_e       r_state;

  req_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_age_nxt;
  logic             w_drop;
  logic             w_accept;
  logic             w_press;

  // The debounced level changes on this edge; a press is that change going high
  assign w_accept = (r_sync2 != r_stable) && (r_db_cnt == DB_LAST);
  assign w_press  = w_accept && r_sync2;

  // Two-flop synchroniser for the asynchronous button line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CLKS consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  // Request FSM state and age registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ_IDLE;
      r_age   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
    end
  end

  // Next-state: press opens a request, lamp acknowledges, age expiry drops (ack wins)
  always_comb begin
    w_state_nxt = r_state;
    w_age_nxt   = r_age;
    w_drop      = 1'b0;
    case (r_state)
      REQ_IDLE: begin
        if (w_press && !i_lamp) begin
          w_state_nxt = REQ_PENDING;
          w_age_nxt   = '0;
        end
      end
      REQ_PENDING: begin
        if (i_lamp) begin
          w_state_nxt = REQ_IDLE;
        end else if (r_age == AGE_LAST) begin
          w_state_nxt = REQ_IDLE;
          w_drop      = 1'b1;
        end else begin
          w_age_nxt = r_age + CNT_W'(1);
        end
      end
      default: w_state_nxt = REQ_IDLE;
    endcase
  end

  assign o_pending = (r_state == REQ_PENDING);
  assign o_drop_c  = w_drop;

endmodule

// File: rtl/elevator_button_panel.sv
// Button-panel front end: 30 independent channels plus registered drop indicator.
module elevator_button_panel
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLKS = 4,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_HALL_BUTTONS-1:0] rawHallButton,
  input  logic [9:1]                  rawCarButton1,
  input  logic [9:1]                  rawCarButton2,
  input  logic [NUM_HALL_BUTTONS-1:0] currentRealFloorButton,
  input  logic [9:1]                  currentInternalButton1,
  input  logic [9:1]                  currentInternalButton2,
  output logic [NUM_HALL_BUTTONS-1:0] newRealFloorButton,
  output logic [9:1]                  newInternalButton1,
  output logic [9:1]                  newInternalButton2,
  output logic                        dropPulse
);

  logic [NUM_PANEL_CHANNELS-1:0] w_raw;
  logic [NUM_PANEL_CHANNELS-1:0] w_lamp;
  logic [NUM_PANEL_CHANNELS-1:0] w_pending;
  logic [NUM_PANEL_CHANNELS-1:0] w_drop;
  logic                          r_drop_pulse;

  // Flatten the three buses into the channel index map
  assign w_raw  = {rawCarButton2, rawCarButton1, rawHallButton};
  assign w_lamp = {currentInternalButton2, currentInternalButton1, currentRealFloorButton};

  for (genvar g = 0; g < NUM_PANEL_CHANNELS; g++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CLKS (DEBOUNCE_CLKS),
      .ACK_TIMEOUT   (ACK_TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (reset),
      .i_raw     (w_raw[g]),
      .i_lamp    (w_lamp[g]),
      .o_pending (w_pending[g]),
      .o_drop_c  (w_drop[g])
    );
  end

  // Register the OR of all per-channel drop flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_drop_pulse <= 1'b0;
    else        r_drop_pulse <= |w_drop;
  end

  assign newRealFloorButton = w_pending[CAR1_BASE-1:HALL_BASE];
  assign newInternalButton1 = w_pending[CAR2_BASE-1:CAR1_BASE];
  assign newInternalButton2 = w_pending[NUM_PANEL_CHANNELS-1:CAR2_BASE];
  assign dropPulse          = r_drop_pulse;

endmodule

// File: tb/tb_elevator_button_panel.sv
// Directed bench for elevator_button_panel (DEBOUNCE_CLKS=4, ACK_TIMEOUT=16).
module tb_elevator_button_panel;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rawHallButton;
  logic [9:1]  rawCarButton1;
  logic [9:1]  rawCarButton2;
  logic [11:0] currentRealFloorButton;
  logic [9:1]  currentInternalButton1;
  logic [9:1]  currentInternalButton2;
  logic [11:0] newRealFloorButton;
  logic [9:1]  newInternalButton1;
  logic [9:1]  newInternalButton2;
  logic        dropPulse;

  // Controller model: hall lamps driven directly, car lamps OR in the new requests
  logic [11:0] lamp_hall;
  logic [9:1]  lamp_car1;
  logic [9:1]  lamp_car2;
  assign currentRealFloorButton = lamp_hall;
  assign currentInternalButton1 = lamp_car1 | newInternalButton1;
  assign currentInternalButton2 = lamp_car2 | newInternalButton2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  elevator_button_panel #(.DEBOUNCE_CLKS(4), .ACK_TIMEOUT(16)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .rawHallButton          (rawHallButton),
    .rawCarButton1          (rawCarButton1),
    .rawCarButton2          (rawCarButton2),
    .currentRealFloorButton (currentRealFloorButton),
    .currentInternalButton1 (currentInternalButton1),
    .currentInternalButton2 (currentInternalButton2),
    .newRealFloorButton     (newRealFloorButton),
    .newInternalButton1     (newInternalButton1),
    .newInternalButton2     (newInternalButton2),
    .dropPulse              (dropPulse)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset, clear all inputs, release just after an edge; next edge is edge 1
  task automatic do_reset();
    reset = 1'b0;
    rawHallButton = '0; rawCarButton1 = '0; rawCarButton2 = '0;
    lamp_hall = '0; lamp_car1 = '0; lamp_car2 = '0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rawHallButton = 12'hFFF; rawCarButton1 = '1; rawCarButton2 = '1;
    lamp_hall = '0; lamp_car1 = '0; lamp_car2 = '0;
    step(8);
    n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL reset_hall: got %h want 000", newRealFloorButton); end
    n_cmp++; if (newInternalButton1 !== 9'h000) begin n_bad++; $display("FAIL reset_car1: got %h want 000", newInternalButton1); end
    n_cmp++; if (newInternalButton2 !== 9'h000) begin n_bad++; $display("FAIL reset_car2: got %h want 000", newInternalButton2); end
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b want 0", dropPulse); end
  endtask

  task automatic test_clean_press();
    do_reset();
    rawHallButton[3] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL press_early edge%0d: got %h want 000", e, newRealFloorButton); end
    end
    step(1);
    n_cmp++; if (newRealFloorButton !== 12'h008) begin n_bad++; $display("FAIL press_edge6: got %h want 008", newRealFloorButton); end
    step(3);
    n_cmp++; if (newRealFloorButton !== 12'h008) begin n_bad++; $display("FAIL press_held: got %h want 008", newRealFloorButton); end
    lamp_hall[3] = 1'b1;
    step(1);
    n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL press_ack: got %h want 000", newRealFloorButton); end
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL press_drop: got %b want 0", dropPulse); end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    do_reset();
    pat = 4'b0101; // sampled at edges 1..4 as 1,0,1,0
    for (int e = 1; e <= 4; e++) begin
      rawCarButton1[5] = pat[e-1];
      step(1);
      n_cmp++; if (newInternalButton1 !== 9'h000) begin n_bad++; $display("FAIL bounce_toggle edge%0d: got %h want 000", e, newInternalButton1); end
    end
    rawCarButton1[5] = 1'b1; // hold begins at edge 5
    for (int e = 5; e <= 9; e++) begin
      step(1);
      n_cmp++; if (newInternalButton1 !== 9'h000) begin n_bad++; $display("FAIL bounce_hold edge%0d: got %h want 000", e, newInternalButton1); end
    end
    step(1);
    n_cmp++; if (newInternalButton1 !== 9'h010) begin n_bad++; $display("FAIL bounce_req: got %h want 010", newInternalButton1); end
    step(1);
    n_cmp++; if (newInternalButton1 !== 9'h000) begin n_bad++; $display("FAIL bounce_ack: got %h want 000", newInternalButton1); end
    step(4);
    n_cmp++; if (newInternalButton1 !== 9'h000) begin n_bad++; $display("FAIL bounce_noreq: got %h want 000", newInternalButton1); end
  endtask

  task automatic test_car_one_cycle();
    do_reset();
    rawCarButton2[2] = 1'b1;
    step(5);
    n_cmp++; if (newInternalButton2 !== 9'h000) begin n_bad++; $display("FAIL car_edge5: got %h want 000", newInternalButton2); end
    step(1);
    n_cmp++; if (newInternalButton2 !== 9'h002) begin n_bad++; $display("FAIL car_edge6: got %h want 002", newInternalButton2); end
    step(1);
    n_cmp++; if (newInternalButton2 !== 9'h000) begin n_bad++; $display("FAIL car_edge7: got %h want 000", newInternalButton2); end
    step(2);
    n_cmp++; if (newInternalButton2 !== 9'h000) begin n_bad++; $display("FAIL car_edge9: got %h want 000", newInternalButton2); end
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL car_drop: got %b want 0", dropPulse); end
  endtask

  task automatic test_timeout();
    do_reset();
    rawHallButton[7] = 1'b1;
    step(5);
    for (int e = 6; e <= 21; e++) begin
      step(1);
      n_cmp++; if (newRealFloorButton !== 12'h080) begin n_bad++; $display("FAIL timeout_held edge%0d: got %h want 080", e, newRealFloorButton); end
      n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL timeout_early_drop edge%0d: got %b want 0", e, dropPulse); end
    end
    step(1);
    n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL timeout_clear: got %h want 000", newRealFloorButton); end
    n_cmp++; if (dropPulse !== 1'b1) begin n_bad++; $display("FAIL timeout_drop: got %b want 1", dropPulse); end
    step(1);
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL timeout_drop_width: got %b want 0", dropPulse); end
    n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL timeout_no_rearm: got %h want 000", newRealFloorButton); end
  endtask

  task automatic test_lamp_already_lit();
    do_reset();
    lamp_hall[0] = 1'b1;
    rawHallButton[0] = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      step(1);
      n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL lit_req edge%0d: got %h want 000", e, newRealFloorButton); end
      n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL lit_drop edge%0d: got %b want 0", e, dropPulse); end
    end
  endtask

  task automatic test_ack_vs_timeout();
    do_reset();
    rawHallButton[1] = 1'b1;
    step(21);
    n_cmp++; if (newRealFloorButton !== 12'h002) begin n_bad++; $display("FAIL coincide_pre: got %h want 002", newRealFloorButton); end
    lamp_hall[1] = 1'b1; // seen at edge 22, the same edge the age expires
    step(1);
    n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL coincide_clear: got %h want 000", newRealFloorButton); end
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL coincide_drop: got %b want 0", dropPulse); end
    step(1);
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL coincide_drop_late: got %b want 0", dropPulse); end
  endtask

  task automatic test_reset_mid_operation();
    do_reset();
    rawHallButton = 12'hA34; // bits 2,4,5,9,11
    step(8);
    n_cmp++; if (newRealFloorButton !== 12'hA34) begin n_bad++; $display("FAIL midrst_pending: got %h want a34", newRealFloorButton); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL midrst_async_clear: got %h want 000", newRealFloorButton); end
    n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL midrst_drop: got %b want 0", dropPulse); end
    step(3);
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      n_cmp++; if (newRealFloorButton !== 12'h000) begin n_bad++; $display("FAIL midrst_early edge%0d: got %h want 000", e, newRealFloorButton); end
      n_cmp++; if (dropPulse !== 1'b0) begin n_bad++; $display("FAIL midrst_drop_after edge%0d: got %b want 0", e, dropPulse); end
    end
    step(1);
    n_cmp++; if (newRealFloorButton !== 12'hA34) begin n_bad++; $display("FAIL midrst_reappear: got %h want a34", newRealFloorButton); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_car_one_cycle();
    test_timeout();
    test_lamp_already_lit();
    test_ack_vs_timeout();
    test_reset_mid_operation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
